// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C write sequencer.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    STOP  = 2'd3
  } seq_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;

  function automatic logic [7:0] addr_byte(input logic [6:0] addr);
    return {addr, I2C_RW_WRITE};
  endfunction

endpackage

// File: rtl/i2c_master_seq_if.sv
// Host-side request / data-pull handshake of the I2C write sequencer.
interface i2c_master_seq_if #(
  parameter int LEN_W = 4
) ();
  logic             req;
  logic [6:0]       addr;
  logic [LEN_W-1:0] len;
  logic [7:0]       wr_data;
  logic             wr_ready;
  logic             busy;
  logic             done;
  logic             nak;

  modport master (output req, addr, len, wr_data, input wr_ready, busy, done, nak);
  modport slave  (input req, addr, len, wr_data, output wr_ready, busy, done, nak);
endinterface

// File: rtl/i2c_scl_gen.sv
// SCL phase counter with decoded strobes one cycle ahead of the half/three-quarter points.
module i2c_scl_gen #(
  parameter int CLK_DIV = 8,
  parameter int DIV_LEN = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  output logic [DIV_LEN-1:0] counter,
  output logic               wrap,
  output logic               half,
  output logic               three_q
);
  localparam logic [DIV_LEN-1:0] LAST   = DIV_LEN'(CLK_DIV - 1);
  localparam logic [DIV_LEN-1:0] HALF_M = DIV_LEN'(CLK_DIV / 2 - 1);
  localparam logic [DIV_LEN-1:0] TQ_M   = DIV_LEN'(CLK_DIV / 2 + CLK_DIV / 4 - 1);
  localparam logic [DIV_LEN-1:0] ONE    = DIV_LEN'(1);
  localparam logic [DIV_LEN-1:0] ZERO   = DIV_LEN'(0);

  // Phase counter: held at zero while disabled, wraps once per SCL period
  always_ff @(posedge clk) begin
    if (!rstn || !en) begin
      counter <= ZERO;
    end else if (wrap) begin
      counter <= ZERO;
    end else begin
      counter <= counter + ONE;
    end
  end

  assign wrap    = (counter == LAST);
  assign half    = (counter == HALF_M);
  assign three_q = (counter == TQ_M);
endmodule

// File: rtl/i2c_master_seq.sv
// Write-only I2C transaction sequencer: START, address+W, len data bytes, STOP.
module i2c_master_seq
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int CLK_DIV  = CLK_FREQ / 100_000,
  parameter int DIV_LEN  = 16,
  parameter int LEN_W    = 4
) (
  input  logic               clk,
  input  logic               rstn,
  i2c_master_seq_if.slave    host,
  output logic [DIV_LEN-1:0] clk_counter,
  output logic               scl_low,
  output logic               sda_low,
  output logic               tx_n,
  output logic [7:0]         tx_data,
  input  logic               tx_ack_en,
  input  logic               tx_ack
);
  seq_state_t       state_r, state_nxt;
  logic [3:0]       bit_cnt_r, bit_cnt_nxt;
  logic [LEN_W-1:0] bytes_left_r, bytes_left_nxt;
  logic [6:0]       addr_r, addr_nxt;
  logic [7:0]       tx_data_r, tx_data_nxt;
  logic             tx_n_r, tx_n_nxt;
  logic             scl_low_r, scl_low_nxt;
  logic             sda_low_r, sda_low_nxt;
  logic             busy_r, busy_nxt;
  logic             nak_r, nak_nxt;
  logic             done_r, done_nxt;
  logic             wr_ready_r, wr_ready_nxt;
  logic             wrap_s, half_s, three_q_s;
  logic             ack_slot_s, last_byte_s, nak_s;

  i2c_scl_gen #(.CLK_DIV(CLK_DIV), .DIV_LEN(DIV_LEN)) u_scl_gen (
    .clk     (clk),
    .rstn    (rstn),
    .en      (state_r != IDLE),
    .counter (clk_counter),
    .wrap    (wrap_s),
    .half    (half_s),
    .three_q (three_q_s)
  );

  assign ack_slot_s  = (bit_cnt_r == 4'd8);
  assign last_byte_s = (bytes_left_r == {LEN_W{1'b0}});
  // A missing acknowledge is treated the same as an explicit NAK
  assign nak_s       = tx_ack_en ? 1'b1 : tx_ack;

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt      = state_r;
    bit_cnt_nxt    = bit_cnt_r;
    bytes_left_nxt = bytes_left_r;
    addr_nxt       = addr_r;
    tx_data_nxt    = tx_data_r;
    tx_n_nxt       = tx_n_r;
    scl_low_nxt    = scl_low_r;
    sda_low_nxt    = sda_low_r;
    busy_nxt       = busy_r;
    nak_nxt        = nak_r;
    done_nxt       = 1'b0;
    wr_ready_nxt   = 1'b0;
    case (state_r)
      IDLE: begin
        scl_low_nxt = 1'b0;
        sda_low_nxt = 1'b0;
        tx_n_nxt    = 1'b1;
        if (host.req) begin
          addr_nxt       = host.addr;
          bytes_left_nxt = host.len;
          nak_nxt        = 1'b0;
          busy_nxt       = 1'b1;
          state_nxt      = START;
        end else begin
          busy_nxt = 1'b0;
        end
      end
      START: begin
        if (half_s) sda_low_nxt = 1'b1;
        else        sda_low_nxt = sda_low_r;
        if (wrap_s) begin
          scl_low_nxt = 1'b1;
          tx_data_nxt = addr_byte(addr_r);
          tx_n_nxt    = 1'b0;
          bit_cnt_nxt = 4'd0;
          state_nxt   = XFER;
        end else begin
          state_nxt = START;
        end
      end
      XFER: begin
        if (wrap_s)      scl_low_nxt = 1'b1;
        else if (half_s) scl_low_nxt = 1'b0;
        else             scl_low_nxt = scl_low_r;
        // START hold ends when SCL rises on bit 0; i2c_tx owns SDA from then on
        if (half_s && bit_cnt_r == 4'd0) sda_low_nxt = 1'b0;
        else                             sda_low_nxt = sda_low_r;
        if (wr_ready_r) tx_data_nxt = host.wr_data;
        else            tx_data_nxt = tx_data_r;
        if (half_s && ack_slot_s && last_byte_s) tx_n_nxt = 1'b1;
        else                                     tx_n_nxt = tx_n_r;
        if (wrap_s && !ack_slot_s) begin
          bit_cnt_nxt = bit_cnt_r + 4'd1;
        end else if (wrap_s && nak_s) begin
          nak_nxt     = 1'b1;
          tx_n_nxt    = 1'b1;
          sda_low_nxt = 1'b1;
          state_nxt   = STOP;
        end else if (wrap_s && !last_byte_s) begin
          wr_ready_nxt   = 1'b1;
          bytes_left_nxt = bytes_left_r - LEN_W'(1);
          bit_cnt_nxt    = 4'd0;
        end else if (wrap_s) begin
          sda_low_nxt = 1'b1;
          state_nxt   = STOP;
        end else begin
          bit_cnt_nxt = bit_cnt_r;
        end
      end
      STOP: begin
        if (half_s) scl_low_nxt = 1'b0;
        else        scl_low_nxt = scl_low_r;
        if (three_q_s) sda_low_nxt = 1'b0;
        else           sda_low_nxt = sda_low_r;
        if (wrap_s) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = STOP;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bit_cnt_r    <= 4'd0;
      bytes_left_r <= {LEN_W{1'b0}};
      addr_r       <= 7'd0;
      tx_data_r    <= 8'hFF;
      tx_n_r       <= 1'b1;
      scl_low_r    <= 1'b0;
      sda_low_r    <= 1'b0;
      busy_r       <= 1'b0;
      nak_r        <= 1'b0;
      done_r       <= 1'b0;
      wr_ready_r   <= 1'b0;
    end else begin
      bit_cnt_r    <= bit_cnt_nxt;
      bytes_left_r <= bytes_left_nxt;
      addr_r       <= addr_nxt;
      tx_data_r    <= tx_data_nxt;
      tx_n_r       <= tx_n_nxt;
      scl_low_r    <= scl_low_nxt;
      sda_low_r    <= sda_low_nxt;
      busy_r       <= busy_nxt;
      nak_r        <= nak_nxt;
      done_r       <= done_nxt;
      wr_ready_r   <= wr_ready_nxt;
    end
  end

  assign host.wr_ready = wr_ready_r;
  assign host.busy     = busy_r;
  assign host.done     = done_r;
  assign host.nak      = nak_r;
  assign scl_low       = scl_low_r;
  assign sda_low       = sda_low_r;
  assign tx_n          = tx_n_r;
  assign tx_data       = tx_data_r;
endmodule

// File: tb/tb_i2c_master_seq.sv
// Directed bench: sequencer + behavioural i2c_tx, open-drain bus and ACKing slave.
module tb_i2c_master_seq;
  import i2c_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] clk_counter;
  logic        scl_low, sda_low, tx_n;
  logic [7:0]  tx_data;
  logic        tx_ack_en = 1'b1;
  logic        tx_ack = 1'b0;

  i2c_master_seq_if #(.LEN_W(4)) hif ();

  i2c_master_seq #(.CLK_DIV(8), .DIV_LEN(16), .LEN_W(4)) dut (
    .clk(clk), .rstn(rstn), .host(hif), .clk_counter(clk_counter),
    .scl_low(scl_low), .sda_low(sda_low), .tx_n(tx_n), .tx_data(tx_data),
    .tx_ack_en(tx_ack_en), .tx_ack(tx_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Open-drain bus
  logic tx_sda = 1'b0;
  logic slv_sda = 1'b0;
  logic scl_b, sda_b;
  assign scl_b = !scl_low;
  assign sda_b = !(sda_low | tx_sda | slv_sda);

  // Behavioural i2c_tx: data changes at Q, ACK sampled just before SCL rises in slot 8
  int tx_bit = 0;
  always @(posedge clk) begin
    if (tx_n) begin
      tx_bit <= 0;
      tx_sda <= 1'b0;
    end else begin
      if (clk_counter == 16'd2) tx_sda <= (tx_bit < 8) ? ~tx_data[3'(7 - tx_bit)] : 1'b0;
      if (clk_counter == 16'd7) tx_bit <= (tx_bit == 8) ? 0 : tx_bit + 1;
    end
    if (!tx_n && tx_bit == 8 && clk_counter == 16'd3) begin
      tx_ack_en <= 1'b0;
      tx_ack    <= sda_b;
    end else if (clk_counter == 16'd7) begin
      tx_ack_en <= 1'b1;
    end
  end

  // Slave / bus monitor driven purely by SCL/SDA levels
  logic       prev_scl = 1'b1, prev_sda = 1'b1, in_ack = 1'b0;
  logic [7:0] shreg = 8'h00;
  int sbit = 0, sbyte = 0, nak_idx = 99, start_cnt = 0, stop_cnt = 0;
  logic [7:0] rx_q[$];
  always @(posedge clk) begin
    prev_scl <= scl_b;
    prev_sda <= sda_b;
    if (prev_scl && scl_b && prev_sda && !sda_b) begin
      start_cnt <= start_cnt + 1;
      sbit <= 0; sbyte <= 0; in_ack <= 1'b0; slv_sda <= 1'b0;
    end else if (prev_scl && scl_b && !prev_sda && sda_b) begin
      stop_cnt <= stop_cnt + 1;
    end else if (!prev_scl && scl_b && sbit < 8) begin
      shreg <= {shreg[6:0], sda_b};
      sbit  <= sbit + 1;
      if (sbit == 7) rx_q.push_back({shreg[6:0], sda_b});
    end else if (prev_scl && !scl_b && sbit == 8) begin
      if (!in_ack) begin
        in_ack  <= 1'b1;
        slv_sda <= (sbyte != nak_idx);
      end else begin
        in_ack <= 1'b0; slv_sda <= 1'b0; sbit <= 0; sbyte <= sbyte + 1;
      end
    end
  end

  // Upstream producer and pulse counters
  logic [7:0] tbl [0:255];
  int wr_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    hif.wr_data = tbl[wr_cnt];
    if (hif.wr_ready) wr_cnt = wr_cnt + 1;
    if (hif.done) done_cnt = done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q[$];

  task automatic run_txn(input string tag, input logic [6:0] a, input logic [3:0] n,
                         input int nak_at, input logic exp_nak, input int exp_wr, input int exp_cyc);
    int rx0, wr0, st0, sp0, cyc;
    logic [31:0] got;
    rx0 = rx_q.size(); wr0 = wr_cnt; st0 = start_cnt; sp0 = stop_cnt;
    nak_idx = nak_at;
    @(negedge clk);
    hif.addr = a; hif.len = n; hif.req = 1'b1;
    @(negedge clk);
    hif.req = 1'b0;
    check_eq({tag, "_busy_accept"}, 32'(hif.busy), 32'd1);
    cyc = 0;
    while (!hif.done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_done"}, 32'(hif.done), 32'd1);
    check_eq({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check_eq({tag, "_busy_at_done"}, 32'(hif.busy), 32'd1);
    check_eq({tag, "_nak"}, 32'(hif.nak), 32'(exp_nak));
    check_eq({tag, "_wr_ready_cnt"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    check_eq({tag, "_starts"}, 32'(start_cnt - st0), 32'd1);
    check_eq({tag, "_stops"}, 32'(stop_cnt - sp0), 32'd1);
    check_eq({tag, "_nbytes"}, 32'(rx_q.size() - rx0), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (rx0 + k < rx_q.size()) ? 32'(rx_q[rx0 + k]) : 32'hFFFF_FFFF;
      check_eq({tag, "_byte"}, got, 32'(exp_q[k]));
    end
    @(negedge clk);
    check_eq({tag, "_busy_after"}, 32'(hif.busy), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int cyc, d0, rx0;
    logic [31:0] got;
    for (int i = 0; i < 256; i++) tbl[i] = 8'h00;
    hif.req = 1'b0; hif.addr = 7'd0; hif.len = 4'd0; rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(hif.busy), 32'd0);
    check_eq("rst_done", 32'(hif.done), 32'd0);
    check_eq("rst_nak", 32'(hif.nak), 32'd0);
    check_eq("rst_wr_ready", 32'(hif.wr_ready), 32'd0);
    check_eq("rst_scl_low", 32'(scl_low), 32'd0);
    check_eq("rst_sda_low", 32'(sda_low), 32'd0);
    check_eq("rst_tx_n", 32'(tx_n), 32'd1);
    check_eq("rst_tx_data", 32'(tx_data), 32'hFF);
    check_eq("rst_counter", 32'(clk_counter), 32'd0);
    rstn = 1'b1;

    // len=2 write: (1 + 3*9 + 1) periods of 8 clocks
    tbl[wr_cnt] = 8'hA5; tbl[wr_cnt + 1] = 8'h3C;
    exp_q = '{8'hA0, 8'hA5, 8'h3C};
    run_txn("len2", 7'h50, 4'd2, 99, 1'b0, 2, 232);

    exp_q = '{8'h42};
    run_txn("probe", 7'h21, 4'd0, 99, 1'b0, 0, 88);

    tbl[wr_cnt] = 8'h11; tbl[wr_cnt + 1] = 8'h22; tbl[wr_cnt + 2] = 8'h33;
    exp_q = '{8'h66, 8'h11, 8'h22};
    run_txn("nak_data", 7'h33, 4'd3, 2, 1'b1, 2, 232);

    exp_q = '{8'hFE};
    run_txn("nak_addr", 7'h7F, 4'd2, 0, 1'b1, 0, 88);

    exp_q.push_back(8'h74);
    for (int k = 0; k < 15; k++) begin
      tbl[wr_cnt + k] = 8'(k * 17 + 3);
      exp_q.push_back(8'(k * 17 + 3));
    end
    run_txn("len_max", 7'h3A, 4'd15, 99, 1'b0, 15, 1168);

    // Reset part-way into the data byte
    tbl[wr_cnt] = 8'h99;
    d0 = wr_cnt;
    @(negedge clk);
    hif.addr = 7'h10; hif.len = 4'd1; hif.req = 1'b1;
    @(negedge clk);
    hif.req = 1'b0;
    cyc = 0;
    while (wr_cnt == d0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rst_mid_wr_ready_seen", 32'(wr_cnt - d0), 32'd1);
    repeat (20) @(negedge clk);
    check_eq("rst_mid_busy_before", 32'(hif.busy), 32'd1);
    d0 = done_cnt;
    rstn = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_scl_low", 32'(scl_low), 32'd0);
    check_eq("rst_mid_sda_low", 32'(sda_low), 32'd0);
    check_eq("rst_mid_tx_n", 32'(tx_n), 32'd1);
    check_eq("rst_mid_busy", 32'(hif.busy), 32'd0);
    check_eq("rst_mid_counter", 32'(clk_counter), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("rst_mid_idle_busy", 32'(hif.busy), 32'd0);

    // req held high: second START immediately after done; addr change while busy ignored
    d0 = done_cnt; rx0 = rx_q.size(); nak_idx = 99;
    @(negedge clk);
    hif.addr = 7'h0A; hif.len = 4'd0; hif.req = 1'b1;
    cyc = 0;
    while (!hif.done && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("b2b_done1", 32'(hif.done), 32'd1);
    check_eq("b2b_busy_at_done", 32'(hif.busy), 32'd1);
    @(negedge clk);
    check_eq("b2b_gap_counter", 32'(clk_counter), 32'd0);
    check_eq("b2b_gap_busy", 32'(hif.busy), 32'd1);
    @(negedge clk);
    check_eq("b2b_start_running", 32'(clk_counter), 32'd1);
    hif.addr = 7'h55;
    repeat (10) @(negedge clk);
    hif.req = 1'b0;
    cyc = 0;
    while (!hif.done && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("b2b_done2", 32'(hif.done), 32'd1);
    check_eq("b2b_nbytes", 32'(rx_q.size() - rx0), 32'd2);
    got = (rx_q.size() > rx0 + 1) ? 32'(rx_q[rx0 + 1]) : 32'hFFFF_FFFF;
    check_eq("b2b_second_addr", got, 32'h14);
    @(negedge clk);
    check_eq("b2b_busy_after", 32'(hif.busy), 32'd0);
    repeat (30) @(negedge clk);
    check_eq("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    check_eq("b2b_idle_counter", 32'(clk_counter), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
